// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver
//   Command-side initiator for the 3-bit team ALU. An upstream sequencer
//   hands over operations on a valid/ready command port. The block drives
//   the ALU operand, opcode and enable pins from registers. It captures each
//   4-bit ALU result, tagged with its opcode, into a DEPTH-entry FIFO, which
//   is returned on a valid/ready response port.
//
//   Ports
//     clk, rst          rising-edge clock, synchronous active-high reset
//     cmd_valid/ready   command handshake; cmd_a, cmd_b (3b), cmd_op (2b)
//     alu_a/b/compute   registered operands/opcode to the ALU
//     alu_en            registered ALU enable, high for the one DRIVE cycle
//     alu_data_out      ALU result (4b), captured at the end of DRIVE
//     rsp_valid/ready   response handshake; rsp_data (4b), rsp_op (2b)
//     issued_count      results written into the FIFO, modulo 256
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a command; ready whenever the FIFO has room
//   DRIVE | ALU inputs valid and enabled; result captured at the closing edge
module alu_cmd_driver #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_a,
  input  logic [2:0] cmd_b,
  input  logic [1:0] cmd_op,
  output logic [2:0] alu_a,
  output logic [2:0] alu_b,
  output logic [1:0] alu_compute,
  output logic       alu_en,
  input  logic [3:0] alu_data_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic [1:0] rsp_op,
  output logic [7:0] issued_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t        state;
  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  // A FIFO write happens on every DRIVE cycle. Room was reserved when the
  // command was accepted, so no full check is needed here.
  assign push      = (state == DRIVE);
  assign pop       = rsp_valid && rsp_ready;
  assign cmd_ready = (state == IDLE) && (count < DEPTH_C);
  assign rsp_valid = (count != '0);
  assign rsp_data  = mem[rptr][3:0];
  assign rsp_op    = mem[rptr][5:4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_compute  <= '0;
      alu_en       <= 1'b0;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      issued_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            alu_a       <= cmd_a;
            alu_b       <= cmd_b;
            alu_compute <= cmd_op;
            alu_en      <= 1'b1;
            state       <= DRIVE;
          end
        end
        DRIVE: begin
          mem[wptr]    <= {alu_compute, alu_data_out};
          wptr         <= wptr + 1'b1;
          issued_count <= issued_count + 1'b1;
          alu_en       <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (pop) rptr <= rptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
module tb_alu_cmd_driver;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_a = '0;
  logic [2:0] cmd_b = '0;
  logic [1:0] cmd_op = '0;
  logic [2:0] alu_a;
  logic [2:0] alu_b;
  logic [1:0] alu_compute;
  logic       alu_en;
  logic [3:0] alu_data_out;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_data;
  logic [1:0] rsp_op;
  logic [7:0] issued_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  alu_cmd_driver #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_compute(alu_compute), .alu_en(alu_en),
    .alu_data_out(alu_data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_op(rsp_op),
    .issued_count(issued_count)
  );

  function automatic logic [3:0] ref_alu(input logic [2:0] a, input logic [2:0] b,
                                         input logic [1:0] op);
    case (op)
      2'b00:   return {1'b0, a & b};
      2'b01:   return {1'b0, a | b};
      2'b10:   return {1'b0, a} + {1'b0, b};
      default: return ~{1'b0, a};
    endcase
  endfunction

  // Stand-in for the combinational ALU attached to the driver.
  assign alu_data_out = alu_en ? ref_alu(alu_a, alu_b, alu_compute) : 4'h0;

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Transaction-level reference: a pending-command flag and a queue of results.
  bit         m_init = 0;
  bit         m_pend = 0;
  logic [2:0] m_a = '0, m_b = '0;
  logic [1:0] m_op = '0;
  int         m_iss = 0;
  logic [5:0] m_q[$];

  always @(posedge clk) begin
    bit hs, pp;
    cyc++;
    if (rst) begin
      m_init = 1; m_pend = 0; m_q.delete(); m_iss = 0;
      m_a = '0; m_b = '0; m_op = '0;
    end else begin
      hs = !m_pend && (m_q.size() < DEPTH) && cmd_valid;
      pp = (m_q.size() > 0) && rsp_ready;
      if (pp) void'(m_q.pop_front());
      if (m_pend) begin
        m_q.push_back({m_op, ref_alu(m_a, m_b, m_op)});
        m_iss = (m_iss + 1) % 256;
        m_pend = 0;
      end else if (hs) begin
        m_pend = 1; m_a = cmd_a; m_b = cmd_b; m_op = cmd_op;
      end
    end
  end

  logic [5:0] dut_log[$];
  int         hs_cyc[$];
  bit         prev_en = 0;

  always @(negedge clk) begin
    if (m_init) begin
      chk("cmd_ready", cmd_ready, int'(!m_pend && m_q.size() < DEPTH));
      chk("alu_en", alu_en, int'(m_pend));
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_compute", alu_compute, m_op);
      chk("rsp_valid", rsp_valid, int'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        chk("rsp_data", rsp_data, m_q[0][3:0]);
        chk("rsp_op", rsp_op, m_q[0][5:4]);
      end
      chk("issued_count", issued_count, m_iss);
      chk("ready_and_en", int'(cmd_ready && alu_en), 0);
      chk("en_two_cycles", int'(prev_en && alu_en), 0);
      prev_en = alu_en;
      if (!rst && rsp_valid && rsp_ready) dut_log.push_back({rsp_op, rsp_data});
      if (!rst && cmd_valid && cmd_ready) hs_cyc.push_back(cyc);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Returns 1 ns after the handshake edge; cmd_valid is left high.
  task automatic send_cmd(input logic [2:0] a, input logic [2:0] b, input logic [1:0] op);
    int n = 0;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 50) begin
        chk("handshake_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_log(input int n);
    int k = 0;
    while (dut_log.size() < n && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (dut_log.size() < n) chk("response_timeout", dut_log.size(), n);
  endtask

  logic [5:0] exp_q[$];

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_issued", issued_count, 0);
    @(posedge clk); #1;

    // ADD 7+7
    rsp_ready = 1'b1;
    send_cmd(3'd7, 3'd7, 2'b10);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("add_en_high", alu_en, 1);
    @(negedge clk);
    chk("add_en_low", alu_en, 0);
    chk("add_rsp_valid", rsp_valid, 1);
    chk("add_rsp_data", rsp_data, 14);
    chk("add_rsp_op", rsp_op, 2);
    chk("add_issued", issued_count, 1);
    @(posedge clk); #1;

    // Back-to-back AND, OR, NOT
    dut_log.delete(); hs_cyc.delete();
    send_cmd(3'd6, 3'd3, 2'b00);
    send_cmd(3'd4, 3'd1, 2'b01);
    send_cmd(3'd5, 3'd0, 2'b11);
    cmd_valid = 1'b0;
    wait_log(3);
    if (hs_cyc.size() == 3) begin
      chk("b2b_gap1", hs_cyc[1] - hs_cyc[0], 2);
      chk("b2b_gap2", hs_cyc[2] - hs_cyc[1], 2);
    end else chk("b2b_hs_count", hs_cyc.size(), 3);
    if (dut_log.size() >= 3) begin
      chk("b2b_rsp0", dut_log[0][3:0], 2);
      chk("b2b_rsp1", dut_log[1][3:0], 5);
      chk("b2b_rsp2", dut_log[2][3:0], 10);
    end

    // Fill the FIFO with backpressure
    rsp_ready = 1'b0;
    repeat (4) send_cmd(3'd1, 3'd1, 2'b10);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("full_cmd_ready", cmd_ready, 0);
    chk("full_rsp_valid", rsp_valid, 1);
    chk("full_rsp_data", rsp_data, 2);
    repeat (3) @(negedge clk);
    chk("full_hold_ready", cmd_ready, 0);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("pop_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Write and pop on the same edge with one entry held
    rsp_ready = 1'b0;
    send_cmd(3'd7, 3'd1, 2'b00);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("one_entry_data", rsp_data, 1);
    @(posedge clk); #1;
    send_cmd(3'd2, 3'd1, 2'b01);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("simul_rsp_valid", rsp_valid, 1);
    chk("simul_rsp_data", rsp_data, 3);
    chk("simul_rsp_op", rsp_op, 1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("simul_drained", rsp_valid, 0);
    @(posedge clk); #1;

    // Reset during DRIVE
    rsp_ready = 1'b1;
    send_cmd(3'd3, 3'd3, 2'b10);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstdrv_rsp_valid", rsp_valid, 0);
    chk("rstdrv_issued", issued_count, 0);
    chk("rstdrv_alu_en", alu_en, 0);
    chk("rstdrv_cmd_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    chk("rstdrv_no_rsp", rsp_valid, 0);
    @(posedge clk); #1;
    dut_log.delete();
    send_cmd(3'd3, 3'd3, 2'b10);
    cmd_valid = 1'b0;
    wait_log(1);
    if (dut_log.size() >= 1) chk("rstdrv_next", dut_log[0], {2'b10, 4'h6});

    // 256 random commands: issued_count wraps to 0
    do_reset();
    rsp_ready = 1'b1;
    dut_log.delete(); exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      logic [2:0] a, b;
      logic [1:0] op;
      a = 3'($urandom); b = 3'($urandom); op = 2'($urandom);
      exp_q.push_back({op, ref_alu(a, b, op)});
      send_cmd(a, b, op);
    end
    cmd_valid = 1'b0;
    wait_log(256);
    @(negedge clk);
    chk("wrap_issued", issued_count, 0);
    chk("wrap_count", dut_log.size(), 256);
    for (int i = 0; i < 256 && i < dut_log.size(); i++)
      if (dut_log[i] != exp_q[i]) chk("wrap_rsp", dut_log[i], exp_q[i]);
    @(posedge clk); #1;

    // Free-running random traffic, occasional reset
    for (int i = 0; i < 1500; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_a = 3'($urandom); cmd_b = 3'($urandom); cmd_op = 2'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
